// File: rtl/axi_lite_txn_arbiter_if.sv
// Purpose: groups the arbiter's request, handshake-strobe and grant signals into one bundle.
// Latency: no logic here; timing is set entirely by the arbiter.
// Backpressure: none; the strobes are observations of slave-side VALID&READY, never driven back.
// Ports (signals): m_arvalid/m_awvalid[1:0] per-master requests; ar/aw/w/r/b_hs slave handshakes;
//   grant[1:0], grant_id, grant_wr, busy, timeout_err from the arbiter.
// Modports: master = requester/environment side, slave = arbiter side.
interface axi_lite_txn_arbiter_if;
    logic [1:0] m_arvalid;
    logic [1:0] m_awvalid;
    logic       ar_hs;
    logic       aw_hs;
    logic       w_hs;
    logic       r_hs;
    logic       b_hs;
    logic [1:0] grant;
    logic       grant_id;
    logic       grant_wr;
    logic       busy;
    logic       timeout_err;

    modport master (
        output m_arvalid, m_awvalid, ar_hs, aw_hs, w_hs, r_hs, b_hs,
        input  grant, grant_id, grant_wr, busy, timeout_err
    );

    modport slave (
        input  m_arvalid, m_awvalid, ar_hs, aw_hs, w_hs, r_hs, b_hs,
        output grant, grant_id, grant_wr, busy, timeout_err
    );
endinterface

// File: rtl/axi_lite_txn_arbiter.sv
// Purpose: round-robin, transaction-level owner select for one AXI4-lite slave shared by two masters.
// Latency: grant registered 1 cycle after request; release 1 cycle after the final handshake or timeout.
// Backpressure: none of its own; holds a grant until the slave-side strobes complete the transaction.
// Ports: CLK, RST_N (async, active-low) plain; bus (slave modport) carries requests, strobes, grant outputs.
// Params: TIMEOUT = cycles without progress before forced release (0 disables), CNT_W = watchdog width.
module axi_lite_txn_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    axi_lite_txn_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    // Counter value at which a further idle busy cycle forces release.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             grant_id_q, grant_id_d;
    logic             grant_wr_q, grant_wr_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic             ptr_q, ptr_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] req;
    logic       win;
    logic       win_wr;
    logic       progress;
    logic       release_now;
    logic       aw_seen;
    logic       w_seen;

    assign req = bus.m_arvalid | bus.m_awvalid;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_wr_d    = grant_wr_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        ptr_d         = ptr_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cnt_d         = cnt_q;
        win           = 1'b0;
        win_wr        = 1'b0;
        progress      = 1'b0;
        release_now   = 1'b0;
        aw_seen       = aw_done_q | bus.aw_hs;
        w_seen        = w_done_q | bus.w_hs;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // Contention resolved by ptr; a lone requester wins regardless of ptr.
                    win        = (req == 2'b11) ? ptr_q : req[1];
                    // Read takes precedence when the winner raises both directions.
                    win_wr     = ~bus.m_arvalid[win];
                    state_d    = win_wr ? S_WR_ADDR : S_RD_ADDR;
                    grant_d    = win ? 2'b10 : 2'b01;
                    grant_id_d = win;
                    grant_wr_d = win_wr;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_RD_ADDR: begin
                if (bus.ar_hs) begin
                    progress = 1'b1;
                    state_d  = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (bus.r_hs) begin
                    progress    = 1'b1;
                    release_now = 1'b1;
                end
            end
            S_WR_ADDR: begin
                // Only a first-time AW or W acceptance counts as progress for the watchdog.
                progress = (bus.aw_hs & ~aw_done_q) | (bus.w_hs & ~w_done_q);
                if (aw_seen && w_seen) begin
                    state_d   = S_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_seen;
                    w_done_d  = w_seen;
                end
            end
            S_WR_RESP: begin
                if (bus.b_hs) begin
                    progress    = 1'b1;
                    release_now = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog: progress in the expiry cycle takes precedence over the timeout.
        if (state_q != S_IDLE) begin
            if (progress) begin
                cnt_d = '0;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                release_now   = 1'b1;
                timeout_err_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (release_now) begin
            state_d    = S_IDLE;
            grant_d    = 2'b00;
            grant_wr_d = 1'b0;
            busy_d     = 1'b0;
            ptr_d      = ~grant_id_q;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            grant_q       <= 2'b00;
            grant_id_q    <= 1'b0;
            grant_wr_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            ptr_q         <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_wr_q    <= grant_wr_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            ptr_q         <= ptr_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_wr    = grant_wr_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
